// File: rtl/inst_fetch_unit.sv
// Instruction fetch: BRAM address generation, in-flight read
// tracking, output FIFO and PC redirect handling.
module inst_fetch_unit #(
  parameter int          ADDR_W    = 14,
  parameter int          MEM_LAT   = 2,
  parameter int          BUF_DEPTH = 4,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  input  logic              stall,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       inst,
  output logic [31:0]       inst_pc,
  output logic              inst_valid,
  output logic              misaligned
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_ERR
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_fpc;

  logic [MEM_LAT-1:0] r_fl_v;
  logic [31:0]        r_fl_pc [MEM_LAT];

  logic [31:0] r_fifo_d  [BUF_DEPTH];
  logic [31:0] r_fifo_pc [BUF_DEPTH];
  logic [PW:0] r_wptr;
  logic [PW:0] r_rptr;

  logic          w_mis;
  logic          w_flush;
  logic          w_push;
  logic          w_pop;
  logic          w_empty;
  logic          w_full;
  logic [PW:0]   w_fcnt;
  logic [CW-1:0] w_infl;
  logic          w_credit;

  assign w_mis   = (redirect_pc[1:0] != 2'b00);
  assign w_fcnt  = r_wptr - r_rptr;
  assign w_empty = (w_fcnt == '0);
  assign w_full  = (w_fcnt == (PW+1)'(BUF_DEPTH));

  // Count reads still travelling through the BRAM pipeline
  always_comb begin
    w_infl = '0;
    for (int i = 0; i < MEM_LAT; i++)
      w_infl = w_infl + CW'(r_fl_v[i]);
  end

  assign w_credit = (w_infl + CW'(w_fcnt)) < CW'(BUF_DEPTH);

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic; a redirect's alignment picks RUN or ERR
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (redirect && w_mis) w_next = S_ERR;
        else                   w_next = S_RUN;
      end
      S_RUN: begin
        if (redirect && w_mis) w_next = S_ERR;
      end
      S_ERR: begin
        if (redirect && !w_mis) w_next = S_RUN;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs: issue only in RUN, with credit, and never on a redirect
  always_comb begin
    mem_en     = 1'b0;
    misaligned = 1'b0;
    unique case (r_state)
      S_RUN:   mem_en     = w_credit && !redirect;
      S_ERR:   misaligned = 1'b1;
      default: mem_en     = 1'b0;
    endcase
  end

  assign mem_addr = mem_en ? r_fpc[ADDR_W+1:2] : '0;

  assign w_flush = redirect || (r_state == S_ERR);
  assign w_push  = r_fl_v[MEM_LAT-1] && !w_flush;
  assign w_pop   = !w_empty && !stall && !w_flush;

  // Fetch PC: redirect target wins over sequential advance
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)         r_fpc <= RESET_PC;
    else if (redirect) r_fpc <= redirect_pc;
    else if (mem_en)   r_fpc <= r_fpc + 32'd4;
  end

  // In-flight shift register, aligned with the BRAM latency
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_fl_v <= '0;
      for (int i = 0; i < MEM_LAT; i++)
        r_fl_pc[i] <= '0;
    end else begin
      r_fl_v[0]  <= mem_en && !w_flush;
      r_fl_pc[0] <= r_fpc;
      for (int i = 1; i < MEM_LAT; i++) begin
        r_fl_v[i]  <= r_fl_v[i-1] && !w_flush;
        r_fl_pc[i] <= r_fl_pc[i-1];
      end
    end
  end

  // Output FIFO pointers; a flush empties it outright
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (w_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Output FIFO storage: returned word paired with its PC
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_fifo_d[i]  <= '0;
        r_fifo_pc[i] <= '0;
      end
    end else if (w_push) begin
      r_fifo_d[r_wptr[PW-1:0]]  <= mem_rdata;
      r_fifo_pc[r_wptr[PW-1:0]] <= r_fl_pc[MEM_LAT-1];
    end
  end

  assign inst_valid = !w_empty;
  assign inst       = w_empty ? '0 : r_fifo_d[r_rptr[PW-1:0]];
  assign inst_pc    = w_empty ? '0 : r_fifo_pc[r_rptr[PW-1:0]];

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rstn) !(w_push && w_full)
  );

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: scoreboard of expected (pc, word)
// pairs filled at each reset/redirect and drained on every pop.
module tb_inst_fetch_unit;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] d;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        mem_en;
  logic [13:0] mem_addr;
  logic [31:0] mem_rdata;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        misaligned;

  logic        w_redirect;
  logic [31:0] w_redirect_pc;
  logic        w_stall;
  logic        w_mem_en;
  logic [3:0]  w_mem_addr;
  logic [31:0] w_mem_rdata;
  logic [31:0] w_inst;
  logic [31:0] w_inst_pc;
  logic        w_inst_valid;
  logic        w_misaligned;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t        sb  [$];
  exp_t        wsb [$];
  logic [3:0]  waq [$];
  bit          w_on = 1'b0;

  always #5 clk = ~clk;

  inst_fetch_unit #(.ADDR_W(14), .MEM_LAT(2), .BUF_DEPTH(4)) u_dut (
    .clk(clk), .rstn(rstn), .redirect(redirect),
    .redirect_pc(redirect_pc), .stall(stall),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid),
    .misaligned(misaligned)
  );

  inst_fetch_unit #(.ADDR_W(4), .MEM_LAT(2), .BUF_DEPTH(4)) u_wrap (
    .clk(clk), .rstn(rstn), .redirect(w_redirect),
    .redirect_pc(w_redirect_pc), .stall(w_stall),
    .mem_en(w_mem_en), .mem_addr(w_mem_addr),
    .mem_rdata(w_mem_rdata),
    .inst(w_inst), .inst_pc(w_inst_pc),
    .inst_valid(w_inst_valid), .misaligned(w_misaligned)
  );

  // BRAM models: word i holds base + i, two-cycle read latency
  logic [13:0] m_q [2];
  logic [3:0]  w_q [2];
  always @(posedge clk) begin
    m_q[0] <= mem_addr;
    m_q[1] <= m_q[0];
    w_q[0] <= w_mem_addr;
    w_q[1] <= w_q[0];
  end
  assign mem_rdata   = 32'hA000_0000 + {18'b0, m_q[1]};
  assign w_mem_rdata = 32'hB000_0000 + {28'b0, w_q[1]};

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  function automatic void sb_fill(input logic [31:0] pc);
    exp_t        e;
    logic [31:0] w;
    sb.delete();
    for (int i = 0; i < 64; i++) begin
      w    = (pc >> 2) + 32'(i);
      e.pc = pc + 32'(4 * i);
      e.d  = 32'hA000_0000 + {18'b0, w[13:0]};
      sb.push_back(e);
    end
  endfunction

  // Consumer side: every accepted word must match the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (rstn && inst_valid && !stall && !redirect) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", inst_pc, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("pc", inst_pc, e.pc);
        chk("inst", inst, e.d);
      end
    end
  end

  always @(negedge clk) begin
    exp_t       e;
    logic [3:0] a;
    if (rstn && w_on && !w_redirect) begin
      if (w_mem_en && waq.size() > 0) begin
        a = waq.pop_front();
        chk("wrap_addr", 32'(w_mem_addr), 32'(a));
      end
      if (w_inst_valid && wsb.size() > 0) begin
        e = wsb.pop_front();
        chk("wrap_pc", w_inst_pc, e.pc);
        chk("wrap_inst", w_inst, e.d);
      end
    end
  end

  task automatic do_redirect(input logic [31:0] pc);
    @(posedge clk); #1;
    redirect    = 1'b1;
    redirect_pc = pc;
    if (pc[1:0] == 2'b00) sb_fill(pc);
    else                  sb.delete();
    @(posedge clk); #1;
    redirect = 1'b0;
    stall    = 1'b0;
  endtask

  task automatic wait_valid(input int max);
    bit got = 1'b0;
    for (int i = 0; i < max && !got; i++) begin
      @(negedge clk);
      got = inst_valid;
    end
    chk("wait_valid", 32'(got), 32'd1);
  endtask

  initial begin
    exp_t e;
    redirect      = 1'b0;
    redirect_pc   = '0;
    stall         = 1'b0;
    w_redirect    = 1'b0;
    w_redirect_pc = '0;
    w_stall       = 1'b0;
    rstn          = 1'b1;
    #1 rstn = 1'b0;
    #2;
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_pc", inst_pc, 32'd0);
    chk("rst_mis", 32'(misaligned), 32'd0);
    repeat (2) @(posedge clk);

    // 1: start-up latency and gap-free stream
    #1 rstn = 1'b1;
    sb_fill(32'h0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t1_latency", 32'(inst_valid), 32'(k == 4));
    end
    @(negedge clk);
    chk("t1_nogap", 32'(inst_valid), 32'd1);

    // 2: stall holds the head and throttles issue
    @(posedge clk); #1 stall = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("t2_hold_pc", inst_pc, 32'h8);
      chk("t2_hold_inst", inst, 32'hA000_0002);
      chk("t2_mem_en", 32'(mem_en), 32'(k == 0));
    end
    @(posedge clk); #1 stall = 1'b0;
    repeat (2) @(negedge clk);

    // 3: redirect mid-stream drops all stale words
    do_redirect(32'h100);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t3_latency", 32'(inst_valid), 32'(k == 3));
    end
    repeat (3) @(negedge clk);

    // 4: misaligned target halts fetch until a good redirect
    do_redirect(32'h102);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t4_mis", 32'(misaligned), 32'd1);
      chk("t4_mem_en", 32'(mem_en), 32'd0);
      chk("t4_valid", 32'(inst_valid), 32'd0);
    end
    do_redirect(32'h200);
    @(negedge clk);
    chk("t4_mis_clr", 32'(misaligned), 32'd0);
    wait_valid(10);
    repeat (2) @(negedge clk);

    // 5: redirect with stall over a full FIFO, then async reset
    @(posedge clk); #1 stall = 1'b1;
    repeat (6) @(negedge clk);
    chk("t5_full_valid", 32'(inst_valid), 32'd1);
    chk("t5_full_mem_en", 32'(mem_en), 32'd0);
    do_redirect(32'h300);
    @(negedge clk);
    chk("t5_flushed", 32'(inst_valid), 32'd0);
    wait_valid(10);
    repeat (3) @(negedge clk);
    #2 rstn = 1'b0;
    sb.delete();
    #1;
    chk("t5_arst_valid", 32'(inst_valid), 32'd0);
    chk("t5_arst_mem_en", 32'(mem_en), 32'd0);
    chk("t5_arst_pc", inst_pc, 32'd0);
    @(posedge clk); #1 rstn = 1'b1;
    sb_fill(32'h0);
    wait_valid(10);
    repeat (2) @(negedge clk);

    // 6: narrow BRAM, address wraps while PC keeps counting
    @(posedge clk); #1;
    w_redirect    = 1'b1;
    w_redirect_pc = 32'h3C;
    wsb.delete();
    waq.delete();
    waq.push_back(4'd15);
    waq.push_back(4'd0);
    waq.push_back(4'd1);
    e.pc = 32'h3C; e.d = 32'hB000_000F; wsb.push_back(e);
    e.pc = 32'h40; e.d = 32'hB000_0000; wsb.push_back(e);
    e.pc = 32'h44; e.d = 32'hB000_0001; wsb.push_back(e);
    w_on = 1'b1;
    @(posedge clk); #1 w_redirect = 1'b0;
    repeat (10) @(negedge clk);
    chk("t6_addr_done", 32'(waq.size()), 32'd0);
    chk("t6_inst_done", 32'(wsb.size()), 32'd0);
    w_on = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
